// File: rtl/hdmi_pkg.sv
// Shared constants, counter widths and state type for the HDMI output core.
// Blanking follows the CEA-861 720p timing.
package hdmi_pkg;

  localparam int HCNT_W = 12;
  localparam int VCNT_W = 11;
  localparam int HRES_W = 11;
  localparam int VRES_W = 10;

  localparam logic [HCNT_W-1:0] H_FP   = 12'd110;
  localparam logic [HCNT_W-1:0] H_SYNC = 12'd40;
  localparam logic [HCNT_W-1:0] H_BP   = 12'd220;
  localparam logic [VCNT_W-1:0] V_FP   = 11'd5;
  localparam logic [VCNT_W-1:0] V_SYNC = 11'd5;
  localparam logic [VCNT_W-1:0] V_BP   = 11'd20;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [HCNT_W-1:0] h_total(input logic [HRES_W-1:0] hres);
    return {1'b0, hres} + H_FP + H_SYNC + H_BP;
  endfunction

  function automatic logic [VCNT_W-1:0] v_total(input logic [VRES_W-1:0] vres);
    return {1'b0, vres} + V_FP + V_SYNC + V_BP;
  endfunction

endpackage

// File: rtl/hdmi_timing_counter.sv
// Horizontal/vertical raster counters; vcnt advances when hcnt wraps.
// Totals are held constant by the caller for the whole run.
module hdmi_timing_counter
  import hdmi_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              run,
  input  logic [HCNT_W-1:0] ht,
  input  logic [VCNT_W-1:0] vt,
  output logic [HCNT_W-1:0] hcnt,
  output logic [VCNT_W-1:0] vcnt
);

  logic [HCNT_W-1:0] hcnt_r;
  logic [VCNT_W-1:0] vcnt_r;

  // Counter state: cleared on reset or load, free-running while in RUN.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hcnt_r <= 12'd0;
      vcnt_r <= 11'd0;
    end else if (load) begin
      hcnt_r <= 12'd0;
      vcnt_r <= 11'd0;
    end else if (run) begin
      if (hcnt_r == ht - 12'd1) begin
        hcnt_r <= 12'd0;
        vcnt_r <= (vcnt_r == vt - 11'd1) ? 11'd0 : vcnt_r + 11'd1;
      end else begin
        hcnt_r <= hcnt_r + 12'd1;
      end
    end else begin
      hcnt_r <= hcnt_r;
      vcnt_r <= vcnt_r;
    end
  end

  assign hcnt = hcnt_r;
  assign vcnt = vcnt_r;

endmodule

// File: rtl/hdmi_out_core.sv
// HDMI video timing and pixel output: IDLE/RUN control, region decode,
// registered sync/enable/RGB outputs and frame-buffer line-fetch strobes.
module hdmi_out_core
  import hdmi_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] hres,
  input  logic [9:0]  vres,
  input  logic [23:0] color,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        ve,
  output logic        read_go,
  output logic        read_next_line,
  output logic        read_done
);

  state_t state_r, next_state_s;
  logic              load_s;
  logic [HRES_W-1:0] hres_r;
  logic [VRES_W-1:0] vres_r;
  logic [HCNT_W-1:0] ht_r;
  logic [VCNT_W-1:0] vt_r;
  logic [HCNT_W-1:0] hcnt_s;
  logic [VCNT_W-1:0] vcnt_s;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic: RUN is only left through reset.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = RUN;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN:     next_state_s = RUN;
      default: next_state_s = IDLE;
    endcase
  end

  // Raster geometry captured when leaving IDLE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hres_r <= 11'd0;
      vres_r <= 10'd0;
      ht_r   <= 12'd0;
      vt_r   <= 11'd0;
    end else if (load_s) begin
      hres_r <= hres;
      vres_r <= vres;
      ht_r   <= h_total(hres);
      vt_r   <= v_total(vres);
    end else begin
      hres_r <= hres_r;
      vres_r <= vres_r;
      ht_r   <= ht_r;
      vt_r   <= vt_r;
    end
  end

  hdmi_timing_counter u_counter (
    .clock (clock),
    .reset (reset),
    .load  (load_s),
    .run   (state_r == RUN),
    .ht    (ht_r),
    .vt    (vt_r),
    .hcnt  (hcnt_s),
    .vcnt  (vcnt_s)
  );

  logic [HCNT_W-1:0] hres_ext_s, hs_start_s;
  logic [VCNT_W-1:0] vres_ext_s, vs_start_s;
  logic h_active_s, v_active_s, hs_s, vs_s, line_end_s;

  assign hres_ext_s = {1'b0, hres_r};
  assign vres_ext_s = {1'b0, vres_r};
  assign hs_start_s = hres_ext_s + H_FP;
  assign vs_start_s = vres_ext_s + V_FP;
  assign h_active_s = hcnt_s < hres_ext_s;
  assign v_active_s = vcnt_s < vres_ext_s;
  assign hs_s       = (hcnt_s >= hs_start_s) && (hcnt_s < hs_start_s + H_SYNC);
  assign vs_s       = (vcnt_s >= vs_start_s) && (vcnt_s < vs_start_s + V_SYNC);
  // A line end only exists when there is at least one active pixel and line.
  assign line_end_s = (hres_r != 11'd0) && v_active_s && (hcnt_s == hres_ext_s);

  // Output registers: one cycle behind the counters, all zero outside RUN.
  always_ff @(posedge clock) begin
    if (!reset || state_r != RUN) begin
      {red, green, blue} <= 24'd0;
      hsync              <= 1'b0;
      vsync              <= 1'b0;
      ve                 <= 1'b0;
      read_go            <= 1'b0;
      read_next_line     <= 1'b0;
      read_done          <= 1'b0;
    end else begin
      {red, green, blue} <= (h_active_s && v_active_s) ? color : 24'd0;
      hsync              <= hs_s;
      vsync              <= vs_s;
      ve                 <= h_active_s && v_active_s;
      read_go            <= (hcnt_s == 12'd0) && (vcnt_s == 11'd0);
      read_next_line     <= line_end_s && (vcnt_s != vres_ext_s - 11'd1);
      read_done          <= line_end_s && (vcnt_s == vres_ext_s - 11'd1);
    end
  end

endmodule

// File: tb/tb_hdmi_out_core.sv
// Randomized bench for hdmi_out_core against a position-in-frame reference model,
// with per-frame totals checked against closed-form counts.
module tb_hdmi_out_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [10:0] hres  = 11'd0;
  logic [9:0]  vres  = 10'd0;
  logic [23:0] color = 24'd0;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, ve, read_go, read_next_line, read_done;

  int vectors    = 0;
  int miscompares = 0;

  hdmi_out_core dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .hres           (hres),
    .vres           (vres),
    .color          (color),
    .red            (red),
    .green          (green),
    .blue           (blue),
    .hsync          (hsync),
    .vsync          (vsync),
    .ve             (ve),
    .read_go        (read_go),
    .read_next_line (read_next_line),
    .read_done      (read_done)
  );

  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] observed();
    return {1'b0, ve, hsync, vsync, read_go, read_next_line, read_done, red, green, blue};
  endfunction

  // Expected outputs for absolute position p (cycles since frame origin).
  function automatic logic [31:0] model(input longint p, input int h, input int v,
                                        input logic [23:0] col);
    int ht, vt, hc, vc;
    logic e_ve, e_hs, e_vs, e_rg, e_rnl, e_rd;
    ht = h + 110 + 40 + 220;
    vt = v + 5 + 5 + 20;
    p  = p % (longint'(ht) * longint'(vt));
    hc = int'(p % ht);
    vc = int'(p / ht);
    e_ve  = (hc < h) && (vc < v);
    e_hs  = (hc >= h + 110) && (hc < h + 150);
    e_vs  = (vc >= v + 5) && (vc < v + 10);
    e_rg  = (hc == 0) && (vc == 0);
    e_rnl = (h > 0) && (v > 0) && (hc == h) && (vc < v - 1);
    e_rd  = (h > 0) && (v > 0) && (hc == h) && (vc == v - 1);
    return {1'b0, e_ve, e_hs, e_vs, e_rg, e_rnl, e_rd, (e_ve ? col : 24'd0)};
  endfunction

  task automatic run_config(input int h, input int v, input int extra, input bit full_frame,
                            input int idle_cycles);
    int ht, vt, frame, ncyc;
    int n_ve, n_runs, n_hs, n_vs, n_rg, n_rnl, n_rd;
    logic prev_ve;
    logic [23:0] col;
    ht = h + 370;
    vt = v + 30;
    frame = ht * vt;
    ncyc = full_frame ? frame + extra : extra;
    n_ve = 0; n_runs = 0; n_hs = 0; n_vs = 0; n_rg = 0; n_rnl = 0; n_rd = 0;
    prev_ve = 1'b0;

    reset = 1'b0;
    repeat (2) begin
      color = 24'($urandom);
      @(posedge clock); #1;
      check_vec("reset", observed(), 32'd0);
    end
    reset = 1'b1;
    start = 1'b0;
    repeat (idle_cycles) begin
      color = 24'($urandom);
      hres  = 11'($urandom);
      vres  = 10'($urandom);
      @(posedge clock); #1;
      check_vec("idle", observed(), 32'd0);
    end
    hres  = 11'(h);
    vres  = 10'(v);
    start = 1'b1;
    @(posedge clock); #1;
    check_vec("load", observed(), 32'd0);
    start = 1'($urandom_range(0, 1));
    hres  = 11'($urandom);
    vres  = 10'($urandom);

    for (int n = 1; n <= ncyc; n++) begin
      col = 24'($urandom);
      color = col;
      @(posedge clock); #1;
      check_vec("run", observed(), model(longint'(n - 1), h, v, col));
      if (n <= frame) begin
        n_ve   += int'(ve);
        n_runs += int'(ve && !prev_ve);
        n_hs   += int'(hsync);
        n_vs   += int'(vsync);
        n_rg   += int'(read_go);
        n_rnl  += int'(read_next_line);
        n_rd   += int'(read_done);
      end
      prev_ve = ve;
    end

    if (full_frame) begin
      check_vec("ve_cycles",   32'(n_ve),   32'(h * v));
      check_vec("ve_runs",     32'(n_runs), 32'(v));
      check_vec("hsync_total", 32'(n_hs),   32'(40 * vt));
      check_vec("vsync_total", 32'(n_vs),   32'(5 * ht));
      check_vec("read_go",     32'(n_rg),   32'd1);
      check_vec("read_next",   32'(n_rnl),  32'(v - 1));
      check_vec("read_done",   32'(n_rd),   32'd1);
    end
  endtask

  initial begin
    run_config(4, 2, 25, 1'b1, 100);
    for (int k = 0; k < 3; k++)
      run_config($urandom_range(1, 16), $urandom_range(1, 3), $urandom_range(5, 400), 1'b1, 3);
    run_config(1280, 720, 2 * 1650 + 10, 1'b0, 2);
    run_config(0, 0, 4000, 1'b0, 2);
    run_config(6, 0, 4000, 1'b0, 2);
    run_config(0, 2, 1500, 1'b0, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
